// File: rtl/full_adder_bist_pkg.sv
// Shared definitions for the full adder self-test controller and its bench.
package full_adder_bist_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_FINISH
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;
  localparam int ERR_W       = 4;
  localparam int CNT_W       = 4;
endpackage

// File: rtl/full_adder_bist_golden.sv
// Combinational reference full adder; produces the expected response for the current stimulus.
module full_adder_golden (
  input  logic a,
  input  logic b,
  input  logic carryin,
  output logic sum,
  output logic carryout
);
  assign sum      = a ^ b ^ carryin;
  assign carryout = (a & b) | (a & carryin) | (b & carryin);
endmodule

// File: rtl/full_adder_bist.sv
// Exhaustive 8-vector self-test of an external full adder: drives each vector,
// lets it settle, compares against a golden model and reports error statistics.
module full_adder_bist
  import full_adder_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_carryin,
  input  logic             dut_sum,
  input  logic             dut_carryout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_fail
);
  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [CNT_W-1:0]   settle_reg;
  logic               rsp_sum_reg;
  logic               rsp_carry_reg;
  logic               exp_sum;
  logic               exp_carry;
  logic               mismatch;

  full_adder_golden u_golden (
    .a        (dut_a),
    .b        (dut_b),
    .carryin  (dut_carryin),
    .sum      (exp_sum),
    .carryout (exp_carry)
  );

  // The response is captured every cycle, so the value compared in CHECK is
  // the one seen after the vector has been held for SETTLE_CYCLES cycles.
  assign mismatch = (rsp_sum_reg != exp_sum) || (rsp_carry_reg != exp_carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      settle_reg    <= '0;
      rsp_sum_reg   <= 1'b0;
      rsp_carry_reg <= 1'b0;
      dut_a         <= 1'b0;
      dut_b         <= 1'b0;
      dut_carryin   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_fail    <= '0;
    end else begin
      rsp_sum_reg   <= dut_sum;
      rsp_carry_reg <= dut_carryout;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg  <= ST_DRIVE;
            idx_reg    <= '0;
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_DRIVE: begin
          {dut_a, dut_b, dut_carryin} <= idx_reg;
          settle_reg <= CNT_W'(SETTLE_CYCLES - 1);
          state_reg  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_reg == '0) begin
            state_reg <= ST_CHECK;
          end else begin
            settle_reg <= settle_reg - CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count != ERR_W'(NUM_VECTORS)) begin
              err_count <= err_count + ERR_W'(1);
            end
            if (err_count == '0) begin
              first_fail <= idx_reg;
            end
          end
          if (idx_reg == IDX_W'(NUM_VECTORS - 1)) begin
            state_reg <= ST_FINISH;
            busy      <= 1'b0;
          end else begin
            idx_reg   <= idx_reg + IDX_W'(1);
            state_reg <= ST_DRIVE;
          end
        end
        ST_FINISH: begin
          done      <= 1'b1;
          pass      <= (err_count == '0);
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_full_adder_bist.sv
// Directed bench: three controllers (settle 2, 1, 3) against modelled adders with injectable faults.
module tb_full_adder_bist;
  import full_adder_bist_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_w [3];
  logic da [3];
  logic db [3];
  logic dc [3];
  logic busy_w [3];
  logic done_w [3];
  logic pass_w [3];
  logic [ERR_W-1:0] err_w [3];
  logic [IDX_W-1:0] ff_w [3];

  int mode = 0;
  logic sum_c, cout_c, sum_r1, cout_r1, sum_r3, cout_r3;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Combinational adder with fault modes for the settle-2 instance
  always_comb begin
    sum_c  = da[0] ^ db[0] ^ dc[0];
    cout_c = (da[0] & db[0]) | (da[0] & dc[0]) | (db[0] & dc[0]);
    case (mode)
      1: sum_c = 1'b0;
      2: cout_c = da[0] & db[0];
      3: cout_c = ~((da[0] & db[0]) | (da[0] & dc[0]) | (db[0] & dc[0]));
      default: ;
    endcase
  end

  // Adders with one register stage on the outputs
  always_ff @(posedge clk) begin
    sum_r1  <= da[1] ^ db[1] ^ dc[1];
    cout_r1 <= (da[1] & db[1]) | (da[1] & dc[1]) | (db[1] & dc[1]);
    sum_r3  <= da[2] ^ db[2] ^ dc[2];
    cout_r3 <= (da[2] & db[2]) | (da[2] & dc[2]) | (db[2] & dc[2]);
  end

  full_adder_bist #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]),
    .dut_a(da[0]), .dut_b(db[0]), .dut_carryin(dc[0]),
    .dut_sum(sum_c), .dut_carryout(cout_c),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .first_fail(ff_w[0])
  );

  full_adder_bist #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]),
    .dut_a(da[1]), .dut_b(db[1]), .dut_carryin(dc[1]),
    .dut_sum(sum_r1), .dut_carryout(cout_r1),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .first_fail(ff_w[1])
  );

  full_adder_bist #(.SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]),
    .dut_a(da[2]), .dut_b(db[2]), .dut_carryin(dc[2]),
    .dut_sum(sum_r3), .dut_carryout(cout_r3),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_count(err_w[2]), .first_fail(ff_w[2])
  );

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Pulse start on instance k, re-pulse at cycles pa/pb (0 = never), count cycles until done.
  task automatic sweep(input int k, input int pa, input int pb, output int cyc);
    int n;
    @(negedge clk);
    start_w[k] = 1'b1;
    @(posedge clk);
    #1;
    start_w[k] = 1'b0;
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      #1;
      n++;
      start_w[k] = (n == pa || n == pb) ? 1'b1 : 1'b0;
      if (n == 1) check("busy_in_sweep", int'(busy_w[k]), 1);
      if (done_w[k]) break;
    end
    start_w[k] = 1'b0;
    if (n >= 300) check("done_timeout", n, 0);
    cyc = n;
  endtask

  typedef struct {
    string name;
    int    mode;
    int    exp_err;
    int    exp_ff;
    int    exp_pass;
  } vec_t;

  vec_t tbl [4];
  int cyc;

  initial begin
    tbl[0] = '{"good",        0, 0, 0, 1};
    tbl[1] = '{"sum_stuck0",  1, 4, 1, 0};
    tbl[2] = '{"cout_ab",     2, 2, 3, 0};
    tbl[3] = '{"cout_inv",    3, 8, 0, 0};
    for (int i = 0; i < 3; i++) start_w[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy_w[0]), 0);
    check("rst_done", int'(done_w[0]), 0);
    check("rst_err", int'(err_w[0]), 0);
    check("rst_stim", int'({da[0], db[0], dc[0]}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Settle-2 vector table
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      sweep(0, 0, 0, cyc);
      $display("[TB] %s: cycles=%0d err=%0d first=%0d pass=%0d", tbl[i].name, cyc,
               err_w[0], ff_w[0], pass_w[0]);
      check({tbl[i].name, "_cycles"}, cyc, 33);
      check({tbl[i].name, "_err"}, int'(err_w[0]), tbl[i].exp_err);
      check({tbl[i].name, "_first"}, int'(ff_w[0]), tbl[i].exp_ff);
      check({tbl[i].name, "_pass"}, int'(pass_w[0]), tbl[i].exp_pass);
      check({tbl[i].name, "_busy_end"}, int'(busy_w[0]), 0);
    end

    // Restarts mid-sweep (cycles 5, 12) and in the FINISH cycle are ignored
    mode = 0;
    sweep(0, 5, 12, cyc);
    $display("[TB] restart_ignored: cycles=%0d err=%0d pass=%0d", cyc, err_w[0], pass_w[0]);
    check("restart_cycles", cyc, 33);
    check("restart_err", int'(err_w[0]), 0);
    check("restart_pass", int'(pass_w[0]), 1);
    sweep(0, 32, 0, cyc);
    check("finish_start_cycles", cyc, 33);
    @(posedge clk);
    #1;
    $display("[TB] finish_start: busy=%0d done=%0d", busy_w[0], done_w[0]);
    check("finish_start_busy", int'(busy_w[0]), 0);
    check("finish_start_done", int'(done_w[0]), 1);

    // Reset at cycle 10 of a faulty sweep
    mode = 1;
    @(negedge clk);
    start_w[0] = 1'b1;
    @(posedge clk);
    #1;
    start_w[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("pre_reset_err", int'(err_w[0]), 1);
    rst_n = 1'b0;
    #1;
    $display("[TB] mid_reset: busy=%0d err=%0d first=%0d", busy_w[0], err_w[0], ff_w[0]);
    check("reset_busy", int'(busy_w[0]), 0);
    check("reset_done", int'(done_w[0]), 0);
    check("reset_pass", int'(pass_w[0]), 0);
    check("reset_err", int'(err_w[0]), 0);
    check("reset_first", int'(ff_w[0]), 0);
    check("reset_stim", int'({da[0], db[0], dc[0]}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    sweep(0, 0, 0, cyc);
    $display("[TB] after_reset: cycles=%0d err=%0d pass=%0d", cyc, err_w[0], pass_w[0]);
    check("after_reset_cycles", cyc, 33);
    check("after_reset_err", int'(err_w[0]), 0);
    check("after_reset_pass", int'(pass_w[0]), 1);

    // Registered adder: one settle cycle is too short, three are enough
    sweep(1, 0, 0, cyc);
    $display("[TB] settle1_reg: cycles=%0d err=%0d first=%0d pass=%0d", cyc, err_w[1],
             ff_w[1], pass_w[1]);
    check("s1_cycles", cyc, 25);
    check("s1_err", int'(err_w[1]), 5);
    check("s1_first", int'(ff_w[1]), 1);
    check("s1_pass", int'(pass_w[1]), 0);
    sweep(2, 0, 0, cyc);
    $display("[TB] settle3_reg: cycles=%0d err=%0d pass=%0d", cyc, err_w[2], pass_w[2]);
    check("s3_cycles", cyc, 41);
    check("s3_err", int'(err_w[2]), 0);
    check("s3_pass", int'(pass_w[2]), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/full_adder_bist.md
FULL_ADDER_BIST -- requirements
Module: full_adder_bist

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: number of clk cycles each vector is held on the DUT before its response is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle request to run one full sweep.
REQ-005 SHALL have ports dut_a, dut_b, dut_carryin  output  1 each  stimulus to the full adder under test.
REQ-006 SHALL have ports dut_sum, dut_carryout  input  1 each  response from the full adder under test.
REQ-007 SHALL have port busy  output  1  high while a sweep is running.
REQ-008 SHALL have port done  output  1  high from sweep completion until the next accepted start or reset.
REQ-009 SHALL have port pass  output  1  valid while done is high; 1 means zero mismatches.
REQ-010 SHALL have port err_count  output  4  number of mismatching vectors in the last sweep, range 0..8.
REQ-011 SHALL have port first_fail  output  3  vector {a,b,carryin} of the first mismatch; 0 if none.

Function
REQ-012 SHALL use an FSM with states IDLE, DRIVE, SETTLE, CHECK, FINISH.
REQ-013 IDLE: outputs stable; on start=1 SHALL go to DRIVE next cycle, clear err_count, first_fail, pass and done, and set vector index to 0.
REQ-014 DRIVE: SHALL present index bits [2:1:0] on dut_a, dut_b, dut_carryin, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
REQ-015 SETTLE: SHALL decrement the settle counter each cycle and go to CHECK when it reaches 0; stimulus held constant throughout.
REQ-016 CHECK: SHALL compute expected sum = a^b^carryin and carryout = majority(a,b,carryin) from the driven stimulus, and compare both against dut_sum/dut_carryout sampled this cycle.
REQ-017 On mismatch SHALL increment err_count (saturating at 8) and, if err_count was 0, capture the index into first_fail.
REQ-018 From CHECK SHALL go to DRIVE with index+1 if index<7, otherwise to FINISH.
REQ-019 FINISH: SHALL set done=1, pass=(err_count==0), busy=0, then return to IDLE; done, pass, err_count and first_fail hold until the next accepted start.
REQ-020 busy SHALL be 1 in DRIVE, SETTLE, CHECK and 0 in IDLE and FINISH.
REQ-021 start while busy=1 SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-022 One sweep SHALL take exactly 8*(SETTLE_CYCLES+2)+1 cycles from the cycle after start to done rising.
REQ-023 Vector index SHALL be 3 bits plus terminal detection; no wrap past 7 within a sweep.
REQ-024 Stimulus outputs SHALL be registered (no combinational path from start to dut_* ports).

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, dut_a=dut_b=dut_carryin=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, index=0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no partial results retained; the first start after release runs a fresh sweep.

Structure
REQ-027 SHALL place the FSM state encoding, vector count (8) and err_count width in a shared package/header used by bench and RTL.
REQ-028 SHALL use one natural sub-module, full_adder_golden, a combinational reference computing expected sum/carryout; the DUT stays outside this block.

Verification
REQ-029 Correct structural full adder connected, SETTLE_CYCLES=2, start pulse -> done rises after 33 cycles, pass=1, err_count=0, first_fail=0.
REQ-030 DUT with sum stuck at 0 -> err_count=4 (vectors 1,2,4,7), first_fail=3'b001, pass=0.
REQ-031 DUT with carryout forced to a&b (ignores carryin) -> err_count=2 (vectors 3,5), first_fail=3'b011.
REQ-032 start pulsed again at cycles 5 and 12 of a running sweep -> ignored; single done at cycle 33, results identical to REQ-029.
REQ-033 rst_n low at cycle 10 of a sweep with faulty DUT -> all outputs 0 immediately; after release and new start with correct DUT -> pass=1, err_count=0.
REQ-034 SETTLE_CYCLES=1 and DUT with 1-cycle registered output -> sweep length 25 cycles, mismatches reported; SETTLE_CYCLES=3 same DUT -> pass=1.
